instruction_loader: RTL
=======================

Name: instruction_loader

Overview:
Upstream feeder for the IF-stage instruction memory. It assembles a byte stream from the debug UART receiver into instruction words and drives the memory's clear, write-strobe and instruction-data inputs. Loading stops on the HALT instruction or when memory reports full. A status handshake (busy/done/overflow/word count) goes to the debug unit.

Parameters:
BYTE_SIZE, 8, bits per received byte
WORD_SIZE_IN_BYTES, 4, bytes per instruction word
MEM_SIZE_IN_WORDS, 64, instruction memory capacity; sizes the word counter
COUNT_SIZE, $clog2(MEM_SIZE_IN_WORDS)+1, width of o_word_count (localparam)

Ports:
i_clk  in  1  system clock; all state on rising edge
i_reset  in  1  asynchronous, active-high reset
i_start  in  1  begin a load session; honoured only in IDLE or DONE
i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
i_rx_data  in  BYTE_SIZE  received byte
i_mem_full  in  1  instruction memory full flag
o_clear  out  1  one-cycle clear pulse to instruction memory
o_instruction_write  out  1  one-cycle write strobe to instruction memory
o_instruction  out  WORD_SIZE_IN_BYTES*BYTE_SIZE  assembled instruction
o_busy  out  1  high in CLEAR, RECV, WRITE
o_done  out  1  high in DONE
o_overflow  out  1  session ended on full without HALT; valid while o_done
o_word_count  out  COUNT_SIZE  words written this session

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; byte counter 0; assembly register 0.
- FSM states: IDLE, CLEAR, RECV, WRITE, DONE.
- IDLE: i_start=1 -> CLEAR. Bytes are ignored.
- CLEAR: o_clear=1 for exactly this cycle. Byte counter, o_word_count and o_overflow are set to 0. Next state is RECV. Bytes are ignored.
- RECV: on i_rx_valid, shift the byte in MSB-first: word={word[23:0],byte}. Increment the byte counter. On the 4th byte, go to WRITE next cycle and reset the byte counter to 0.
- o_instruction is registered. It holds the assembled word from entry to WRITE until the next assembly completes.
- WRITE (one cycle): o_instruction_write = !i_mem_full (combinational from state).
  - If i_mem_full=1: no write; o_overflow<=1; go to DONE.
  - Else: o_word_count+1.
  - If o_instruction==INSTRUCTION_HALT, go to DONE (o_overflow stays 0); else go to RECV.
- A byte with i_rx_valid in the WRITE cycle is accepted as byte 0 of the next word, unless WRITE exits to DONE.
- DONE: o_done=1 held. i_start -> CLEAR (new session). Bytes are ignored.
- i_start outside IDLE/DONE is ignored.
- A partial word (fewer than 4 bytes) is never written. It is discarded only by reset or by a new session.
- HALT is itself written. The loader does no further address or compaction handling.
- o_word_count saturates at MEM_SIZE_IN_WORDS.
- Latency: 4th byte strobe at edge N -> o_instruction_write high in cycle N+1.

Decomposition:
- Shared header instruction_memory.vh holds BYTE_SIZE, the default sizes, INSTRUCTION_HALT (32'hFC000000), and the CLEAR/HIGH/LOW macros.
- FSM state encodings are local to the module.
- Natural sub-module: byte_assembler (shift register plus byte counter, with a word_ready pulse). The FSM remains in instruction_loader.

Test Plan:
- Reset asserted mid-RECV -> all outputs 0 asynchronously; state returns to IDLE.
- i_start; bytes 20 01 00 05 then FC 00 00 00 -> o_clear one cycle, then writes 0x20010005 and 0xFC000000; o_word_count=2; o_done=1; o_overflow=0.
- Bytes 11 22 33 44 while IDLE -> no write and o_busy=0. After i_start, bytes AA BB CC DD -> writes 0xAABBCCDD.
- Byte strobe in the same cycle as o_instruction_write -> that byte is the MSB of the next written word.
- i_mem_full forced high after 2 words, 3rd word 0x12345678 -> no 3rd write; o_overflow=1; o_done=1; o_word_count=2.
- i_start from DONE with 2 bytes buffered from a prior reset-free abort -> o_clear pulse; counts 0; the next 4 bytes form a clean word.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// rtl/instruction_loader_pkg.sv - shared sizes and constants for the instruction loader
// Contents: default byte/word/memory sizes, the HALT opcode word and a counter-width helper.
package instruction_loader_pkg;

  localparam int DEFAULT_BYTE_SIZE          = 8;
  localparam int DEFAULT_WORD_SIZE_IN_BYTES = 4;
  localparam int DEFAULT_MEM_SIZE_IN_WORDS  = 64;

  localparam logic [31:0] INSTRUCTION_HALT = 32'hFC00_0000;

  // Width needed to hold 0..mem_words inclusive.
  function automatic int count_width(input int mem_words);
    return $clog2(mem_words) + 1;
  endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// rtl/instruction_loader_if.sv - loader bus: session control, UART byte input, memory write and status
// master: loader side (drives clear/write/instruction and status); slave: debug unit / memory / UART side.
interface instruction_loader_if
  import instruction_loader_pkg::*;
#(
  parameter int BYTE_SIZE          = DEFAULT_BYTE_SIZE,
  parameter int WORD_SIZE_IN_BYTES = DEFAULT_WORD_SIZE_IN_BYTES,
  parameter int MEM_SIZE_IN_WORDS  = DEFAULT_MEM_SIZE_IN_WORDS
);

  localparam int WORD_W     = WORD_SIZE_IN_BYTES * BYTE_SIZE;
  localparam int COUNT_SIZE = count_width(MEM_SIZE_IN_WORDS);

  logic                  i_start;
  logic                  i_rx_valid;
  logic [BYTE_SIZE-1:0]  i_rx_data;
  logic                  i_mem_full;
  logic                  o_clear;
  logic                  o_instruction_write;
  logic [WORD_W-1:0]     o_instruction;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_overflow;
  logic [COUNT_SIZE-1:0] o_word_count;

  modport master (
    input  i_start, i_rx_valid, i_rx_data, i_mem_full,
    output o_clear, o_instruction_write, o_instruction,
    output o_busy, o_done, o_overflow, o_word_count
  );

  modport slave (
    output i_start, i_rx_valid, i_rx_data, i_mem_full,
    input  o_clear, o_instruction_write, o_instruction,
    input  o_busy, o_done, o_overflow, o_word_count
  );

endinterface

// File: rtl/instruction_loader_byte_assembler.sv
// rtl/instruction_loader_byte_assembler.sv - MSB-first byte-to-word shift register with byte counter
// Ports: i_clk, i_reset (async, active-high); clear restarts a word; accept gates byte_valid;
// byte_data in; word = last completed word (registered); word_ready = combinational completion pulse.
module instruction_loader_byte_assembler
  import instruction_loader_pkg::*;
#(
  parameter int BYTE_SIZE          = DEFAULT_BYTE_SIZE,
  parameter int WORD_SIZE_IN_BYTES = DEFAULT_WORD_SIZE_IN_BYTES
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset,
  input  logic                                  clear,
  input  logic                                  accept,
  input  logic                                  byte_valid,
  input  logic [BYTE_SIZE-1:0]                  byte_data,
  output logic [WORD_SIZE_IN_BYTES*BYTE_SIZE-1:0] word,
  output logic                                  word_ready
);

  localparam int WORD_W = WORD_SIZE_IN_BYTES * BYTE_SIZE;
  localparam int CNT_W  = (WORD_SIZE_IN_BYTES > 1) ? $clog2(WORD_SIZE_IN_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(WORD_SIZE_IN_BYTES - 1);

  logic [WORD_W-1:0] shift_q;
  logic [WORD_W-1:0] shift_next;
  logic [CNT_W-1:0]  byte_cnt;
  logic              take;

  assign take       = accept && byte_valid;
  assign shift_next = (shift_q << BYTE_SIZE) | WORD_W'(byte_data);
  // Completion is visible in the same cycle as the last strobe so the FSM
  // can enter WRITE on that very edge.
  assign word_ready = take && (byte_cnt == LAST_BYTE);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shift_q  <= '0;
      byte_cnt <= '0;
      word     <= '0;
    end else if (clear) begin
      shift_q  <= '0;
      byte_cnt <= '0;
    end else if (take) begin
      shift_q <= shift_next;
      if (word_ready) begin
        byte_cnt <= '0;
        word     <= shift_next;
      end else begin
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - loads instruction memory from a UART byte stream until HALT or full
// Ports: i_clk, i_reset (async, active-high); bus (instruction_loader_if.master): i_start, i_rx_valid,
// i_rx_data, i_mem_full in; o_clear, o_instruction_write, o_instruction, o_busy, o_done,
// o_overflow, o_word_count out.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int BYTE_SIZE          = DEFAULT_BYTE_SIZE,
  parameter int WORD_SIZE_IN_BYTES = DEFAULT_WORD_SIZE_IN_BYTES,
  parameter int MEM_SIZE_IN_WORDS  = DEFAULT_MEM_SIZE_IN_WORDS
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  instruction_loader_if.master bus
);

  localparam int WORD_W     = WORD_SIZE_IN_BYTES * BYTE_SIZE;
  localparam int COUNT_SIZE = count_width(MEM_SIZE_IN_WORDS);
  localparam logic [COUNT_SIZE-1:0] COUNT_MAX = COUNT_SIZE'(MEM_SIZE_IN_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RECV,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  accept;
  logic                  word_ready;
  logic [WORD_W-1:0]     word;
  logic                  is_halt;
  logic                  overflow_q;
  logic [COUNT_SIZE-1:0] word_count_q;

  instruction_loader_byte_assembler #(
    .BYTE_SIZE          (BYTE_SIZE),
    .WORD_SIZE_IN_BYTES (WORD_SIZE_IN_BYTES)
  ) u_assembler (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .clear      (state_q == S_CLEAR),
    .accept     (accept),
    .byte_valid (bus.i_rx_valid),
    .byte_data  (bus.i_rx_data),
    .word       (word),
    .word_ready (word_ready)
  );

  assign is_halt = (word == WORD_W'(INSTRUCTION_HALT));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d                 = state_q;
    accept                  = 1'b0;
    bus.o_clear             = 1'b0;
    bus.o_instruction_write = 1'b0;
    bus.o_busy              = 1'b0;
    bus.o_done              = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        bus.o_clear = 1'b1;
        bus.o_busy  = 1'b1;
        state_d     = S_RECV;
      end
      S_RECV: begin
        bus.o_busy = 1'b1;
        accept     = 1'b1;
        if (word_ready) state_d = S_WRITE;
      end
      S_WRITE: begin
        bus.o_busy              = 1'b1;
        bus.o_instruction_write = !bus.i_mem_full;
        if (bus.i_mem_full || is_halt) begin
          state_d = S_DONE;
        end else begin
          // Session continues: a byte arriving now starts the next word.
          state_d = S_RECV;
          accept  = 1'b1;
        end
      end
      S_DONE: begin
        bus.o_done = 1'b1;
        if (bus.i_start) state_d = S_CLEAR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      overflow_q   <= 1'b0;
      word_count_q <= '0;
    end else if (state_q == S_CLEAR) begin
      overflow_q   <= 1'b0;
      word_count_q <= '0;
    end else if (state_q == S_WRITE) begin
      if (bus.i_mem_full) begin
        overflow_q <= 1'b1;
      end else if (word_count_q != COUNT_MAX) begin
        word_count_q <= word_count_q + 1'b1;
      end
    end
  end

  assign bus.o_instruction = word;
  assign bus.o_overflow    = overflow_q;
  assign bus.o_word_count  = word_count_q;

endmodule
